// File: rtl/uart_ascii_rx.sv
// UART byte receiver feeding CharDisplay's ascii/ascii_val strobe, 16x oversampled in the clk domain.
// Define UART_ASCII_RX_PARITY_EN for 8E1 frames with parity checking; default build is 8N1.
module uart_ascii_rx #(
    parameter int unsigned p_clk_freq = 50_000_000,
    parameter int unsigned p_baud     = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] ascii,
    output logic       ascii_val,
    output logic       frame_err
);

    localparam int unsigned DIV_RAW = (p_clk_freq + 8 * p_baud) / (16 * p_baud);
    localparam int unsigned p_div   = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int unsigned DIV_W   = (p_div > 1) ? $clog2(p_div) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(p_div - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd4;
`ifdef UART_ASCII_RX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;
`endif

    logic [1:0]       sync_q;
    logic [1:0]       fill_q;
    logic             rx_s;

    logic [2:0]       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       os_q, os_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       ascii_q, ascii_d;
    logic             val_q, val_d;
    logic             ferr_q, ferr_d;
    logic             armed_q, armed_d;
    logic             tick;
    logic             frame_ok;
`ifdef UART_ASCII_RX_PARITY_EN
    logic             perr_q, perr_d;
`endif

    // fill_q marks when the synchroniser holds a genuine line sample rather than its reset value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '1;
            fill_q <= '0;
        end else begin
            sync_q <= {sync_q[0], rx};
            fill_q <= {fill_q[0], 1'b1};
        end
    end

    assign rx_s = sync_q[1];
    assign tick = (state_q != ST_IDLE) && (div_q == DIV_LAST);

`ifdef UART_ASCII_RX_PARITY_EN
    assign frame_ok = rx_s && !perr_q;
`else
    assign frame_ok = rx_s;
`endif

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        os_d    = os_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        ascii_d = ascii_q;
        val_d   = 1'b0;
        ferr_d  = 1'b0;
        armed_d = armed_q;
`ifdef UART_ASCII_RX_PARITY_EN
        perr_d  = perr_q;
`endif

        if (fill_q[1] && rx_s) begin
            armed_d = 1'b1;
        end

        if (state_q != ST_IDLE) begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
        end
        if (tick) begin
            os_d = os_q + 4'd1;
        end

        case (state_q)
            ST_IDLE: begin
                div_d = '0;
                os_d  = '0;
                // armed_q blocks a line that is low from reset or still in a break
                if (armed_q && !rx_s) begin
                    state_d = ST_START;
                    bit_d   = '0;
`ifdef UART_ASCII_RX_PARITY_EN
                    perr_d  = 1'b0;
`endif
                end
            end
            ST_START: begin
                if (tick && os_q == 4'd7) begin
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        os_d    = '0;
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (tick && os_q == 4'd15) begin
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_ASCII_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_ASCII_RX_PARITY_EN
            ST_PARITY: begin
                if (tick && os_q == 4'd15) begin
                    if (rx_s != ^shift_q) begin
                        perr_d = 1'b1;
                    end
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                // leaving at mid-stop lets a back-to-back start edge be caught on time
                if (tick && os_q == 4'd15) begin
                    state_d = ST_IDLE;
                    if (frame_ok) begin
                        ascii_d = shift_q;
                        val_d   = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                        if (!rx_s) begin
                            armed_d = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            os_q    <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            ascii_q <= '0;
            val_q   <= 1'b0;
            ferr_q  <= 1'b0;
            armed_q <= 1'b0;
`ifdef UART_ASCII_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            os_q    <= os_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            ascii_q <= ascii_d;
            val_q   <= val_d;
            ferr_q  <= ferr_d;
            armed_q <= armed_d;
`ifdef UART_ASCII_RX_PARITY_EN
            perr_q  <= perr_d;
`endif
        end
    end

    assign ascii     = ascii_q;
    assign ascii_val = val_q;
    assign frame_err = ferr_q;

endmodule
